// File: rtl/goertzel_bank.sv
// Multi-bin Goertzel filter bank: latches per-bin 20.44 coefficients once, runs the recursion over
// N-sample frames with one datapath shared across NF bins, then streams per-bin re/im results out.
module goertzel_bank #(
   parameter int NF = 11,
   parameter int N  = 256,
   parameter int SW = 16
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                coef_valid,
   input  logic [NF-1:0][63:0] alpha_i,
   input  logic [NF-1:0][63:0] cos_i,
   input  logic [NF-1:0][63:0] sin_i,
   input  logic                smp_valid,
   input  logic [SW-1:0]       smp_i,
   output logic                smp_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_bin,
   output logic [63:0]         out_re,
   output logic [63:0]         out_im,
   output logic                busy
);

   localparam int BW = (NF > 1) ? $clog2(NF) : 1;
   localparam int CW = $clog2(N);
   localparam logic [BW-1:0] BIN_LAST = BW'(NF - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_SMP = 3'd1,
      ITER     = 3'd2,
      CALC     = 3'd3,
      OUT      = 3'd4,
      CLEAR    = 3'd5
   } state_t;

   state_t state_r, state_s;

   logic [NF-1:0][63:0] alpha_r, cos_r, sin_r;
   logic [63:0]         s1_r [NF];
   logic [63:0]         s2_r [NF];
   logic [63:0]         x_r;
   logic [BW-1:0]       bin_r;
   logic [CW-1:0]       cnt_r;
   logic [63:0]         smp_x_s;
   logic [63:0]         s0_s, re_s, im_s;

   // 20.44 x 20.44 product: arithmetic shift floors, truncation to 64 bits wraps
   function automatic logic [63:0] fx_mul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] ea;
      logic signed [127:0] eb;
      ea = {{64{a[63]}}, a};
      eb = {{64{b[63]}}, b};
      return 64'((ea * eb) >>> 7'd44);
   endfunction

   assign smp_x_s = {20'($signed(smp_i)), 44'd0};

   // Shared datapath for the recursion step and the final per-bin result
   always_comb begin
      s0_s = x_r + fx_mul(alpha_r[bin_r], s1_r[bin_r]) - s2_r[bin_r];
      re_s = s1_r[bin_r] - fx_mul(s2_r[bin_r], cos_r[bin_r]);
      im_s = fx_mul(s2_r[bin_r], sin_r[bin_r]);
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (coef_valid) state_s = WAIT_SMP;
            else            state_s = IDLE;
         end
         WAIT_SMP: begin
            if (smp_valid) state_s = ITER;
            else           state_s = WAIT_SMP;
         end
         ITER: begin
            if (bin_r == BIN_LAST) begin
               if (cnt_r == CNT_LAST) state_s = CALC;
               else                   state_s = WAIT_SMP;
            end else begin
               state_s = ITER;
            end
         end
         CALC: state_s = OUT;
         OUT: begin
            if (out_ready) begin
               if (bin_r == BIN_LAST) state_s = CLEAR;
               else                   state_s = CALC;
            end else begin
               state_s = OUT;
            end
         end
         CLEAR:   state_s = WAIT_SMP;
         default: state_s = IDLE;
      endcase
   end

   // Handshake/status outputs are registered from the next state so they line up with state_r
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         smp_ready <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         smp_ready <= (state_s == WAIT_SMP);
         out_valid <= (state_s == OUT);
         busy      <= (state_s != IDLE) && (state_s != WAIT_SMP);
      end
   end

   // Coefficients, recursion state, counters and result registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         alpha_r <= {NF{64'd0}};
         cos_r   <= {NF{64'd0}};
         sin_r   <= {NF{64'd0}};
         for (int i = 0; i < NF; i++) begin
            s1_r[i] <= 64'd0;
            s2_r[i] <= 64'd0;
         end
         x_r     <= 64'd0;
         bin_r   <= BW'(0);
         cnt_r   <= CW'(0);
         out_bin <= 8'd0;
         out_re  <= 64'd0;
         out_im  <= 64'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (coef_valid) begin
                  alpha_r <= alpha_i;
                  cos_r   <= cos_i;
                  sin_r   <= sin_i;
               end
            end
            WAIT_SMP: begin
               if (smp_valid) begin
                  x_r   <= smp_x_s;
                  bin_r <= BW'(0);
               end
            end
            ITER: begin
               s2_r[bin_r] <= s1_r[bin_r];
               s1_r[bin_r] <= s0_s;
               if (bin_r == BIN_LAST) begin
                  if (cnt_r == CNT_LAST) begin
                     cnt_r <= CW'(0);
                     bin_r <= BW'(0);
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end else begin
                  bin_r <= bin_r + BW'(1);
               end
            end
            CALC: begin
               out_re  <= re_s;
               out_im  <= im_s;
               out_bin <= 8'(bin_r);
            end
            OUT: begin
               if (out_ready && (bin_r != BIN_LAST)) bin_r <= bin_r + BW'(1);
            end
            CLEAR: begin
               for (int i = 0; i < NF; i++) begin
                  s1_r[i] <= 64'd0;
                  s2_r[i] <= 64'd0;
               end
            end
            default: begin
               bin_r <= BW'(0);
            end
         endcase
      end
   end

endmodule
